resp_misr_compactor: RTL and testbench

- Synthesizable response compactor that sits directly downstream of an ISCAS85 circuit-under-test, default sized for c7552.
- Each cycle in which the stimulus side flags a settled response, it folds the CUT's primary outputs into a multiple-input signature register (MISR).
- After a programmed number of vectors it freezes the signature and compares it against a golden value.
- Replaces per-vector file dumps of CUT outputs in on-chip aging runs; one 32-bit signature is read instead of 108 bits x N vectors.

---
 rtl/resp_misr_compactor.sv | 117 +++++++++++
 tb/tb_resp_misr_compactor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr_compactor.sv
// Response compactor for an ISCAS85 CUT. It folds each settled response into a Galois MISR
// and, after a fixed number of vectors, freezes the signature and checks it against a golden value.
module resp_misr_compactor #(
    parameter int               OUT_WIDTH  = 108,
    parameter int               SIG_W      = 32,
    parameter logic [SIG_W-1:0] POLY       = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED       = 32'hFFFFFFFF,
    parameter int               VEC_LENGTH = 31,
    localparam int              CNT_W      = $clog2(VEC_LENGTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 resp_valid,
    input  logic [OUT_WIDTH-1:0] resp_data,
    input  logic [SIG_W-1:0]     golden_sig,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_count,
    output logic [SIG_W-1:0]     signature
);

    localparam int NCHUNK = (OUT_WIDTH + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic [SIG_W-1:0]        sig_next;
    logic [CNT_W-1:0]        count_next;
    logic                    pass_next;
    logic [NCHUNK*SIG_W-1:0] padded;
    logic [SIG_W-1:0]        fold;
    logic [SIG_W-1:0]        step;
    logic                    last_vec;

    // The response is zero-extended so the top chunk can be narrower than SIG_W.
    assign padded = (NCHUNK*SIG_W)'(resp_data);

    always_comb begin
        fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ padded[i*SIG_W +: SIG_W];
        end
    end

    assign step     = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ fold;
    assign last_vec = (vec_count == CNT_W'(VEC_LENGTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= '0;
            vec_count <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_next;
            signature <= sig_next;
            vec_count <= count_next;
            pass      <= pass_next;
        end
    end

    // abort takes priority over every other request in RUN and DONE.
    always_comb begin
        state_next = state;
        sig_next   = signature;
        count_next = vec_count;
        pass_next  = pass;
        unique case (state)
            IDLE: begin
                pass_next = 1'b0;
                if (start) begin
                    sig_next   = SEED;
                    count_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    pass_next  = 1'b0;
                    state_next = IDLE;
                end else if (resp_valid) begin
                    sig_next   = step;
                    count_next = vec_count + CNT_W'(1);
                    if (last_vec) begin
                        pass_next  = (step == golden_sig);
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    pass_next  = 1'b0;
                    state_next = IDLE;
                end else if (start) begin
                    sig_next   = SEED;
                    count_next = '0;
                    pass_next  = 1'b0;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Scoreboard bench for resp_misr_compactor: a full-length instance (31 vectors) and a
// single-vector instance; expected final signatures are queued and checked when done rises.
module tb_resp_misr_compactor;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    typedef struct packed {
        logic [31:0] sig;
        logic        pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic         a_start, a_abort, a_valid;
    logic [107:0] a_data;
    logic [31:0]  a_golden;
    logic         a_busy, a_done, a_pass;
    logic [4:0]   a_count;
    logic [31:0]  a_sig;

    logic         b_start, b_abort, b_valid;
    logic [107:0] b_data;
    logic [31:0]  b_golden;
    logic         b_busy, b_done, b_pass;
    logic [0:0]   b_count;
    logic [31:0]  b_sig;

    int checks = 0;
    int errors = 0;
    int a_done_rises = 0;
    int b_done_rises = 0;
    exp_t a_q[$];
    exp_t b_q[$];

    logic [107:0] vecs[31];
    logic [31:0]  model;
    logic [31:0]  held;

    resp_misr_compactor dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (a_start),
        .abort      (a_abort),
        .resp_valid (a_valid),
        .resp_data  (a_data),
        .golden_sig (a_golden),
        .busy       (a_busy),
        .done       (a_done),
        .pass       (a_pass),
        .vec_count  (a_count),
        .signature  (a_sig)
    );

    resp_misr_compactor #(.VEC_LENGTH(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .abort      (b_abort),
        .resp_valid (b_valid),
        .resp_data  (b_data),
        .golden_sig (b_golden),
        .busy       (b_busy),
        .done       (b_done),
        .pass       (b_pass),
        .vec_count  (b_count),
        .signature  (b_sig)
    );

    always #5 clk = ~clk;

    // Reference fold: each output bit lands on signature lane (bit index mod 32).
    function automatic logic [31:0] ref_fold(input logic [107:0] d);
        logic [31:0] f = '0;
        for (int b = 0; b < 108; b++) f[b % 32] = f[b % 32] ^ d[b];
        return f;
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [107:0] d);
        logic [31:0] n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ ref_fold(d);
    endfunction

    function automatic logic [107:0] rand108();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic vl, input logic [107:0] d);
        a_start = st;
        a_abort = ab;
        a_valid = vl;
        a_data  = d;
        tick();
        a_start = 1'b0;
        a_abort = 1'b0;
        a_valid = 1'b0;
    endtask

    task automatic applyStimulusB(input logic st, input logic ab, input logic vl, input logic [107:0] d);
        b_start = st;
        b_abort = ab;
        b_valid = vl;
        b_data  = d;
        tick();
        b_start = 1'b0;
        b_abort = 1'b0;
        b_valid = 1'b0;
    endtask

    // Monitor: pops one expected result for every rising edge of done.
    logic a_done_prev = 1'b0;
    logic b_done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (a_done && !a_done_prev) begin
            a_done_rises++;
            checks++;
            if (a_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL a_unexpected_done: got done=1, expected no completion");
            end else begin
                e = a_q.pop_front();
                if (a_sig !== e.sig || a_pass !== e.pass) begin
                    errors++;
                    $display("[TB] FAIL a_final: got sig=%h pass=%b, expected sig=%h pass=%b",
                             a_sig, a_pass, e.sig, e.pass);
                end
            end
        end
        if (b_done && !b_done_prev) begin
            b_done_rises++;
            checks++;
            if (b_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL b_unexpected_done: got done=1, expected no completion");
            end else begin
                e = b_q.pop_front();
                if (b_sig !== e.sig || b_pass !== e.pass) begin
                    errors++;
                    $display("[TB] FAIL b_final: got sig=%h pass=%b, expected sig=%h pass=%b",
                             b_sig, b_pass, e.sig, e.pass);
                end
            end
        end
        a_done_prev <= a_done;
        b_done_prev <= b_done;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_valid = 0; a_data = '0; a_golden = '0;
        b_start = 0; b_abort = 0; b_valid = 0; b_data = '0; b_golden = '0;
        tick();
        tick();
        checkOutput("reset_sig", a_sig, 0);
        checkOutput("reset_count", a_count, 0);
        checkOutput("reset_flags", {a_busy, a_done, a_pass}, 0);
        rst_n = 1'b1;

        // Reset in the middle of a run.
        applyStimulus(1, 0, 0, '0);
        checkOutput("start_sig", a_sig, SEED);
        checkOutput("start_busy", a_busy, 1);
        model = SEED;
        for (int i = 0; i < 5; i++) begin
            a_data = rand108();
            model  = ref_step(model, a_data);
            applyStimulus(0, 0, 1, a_data);
        end
        checkOutput("run5_count", a_count, 5);
        checkOutput("run5_sig", a_sig, model);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_sig", a_sig, 0);
        checkOutput("midrst_count", a_count, 0);
        checkOutput("midrst_flags", {a_busy, a_done, a_pass}, 0);

        // Single-vector instance: zero response, matching golden.
        b_golden = 32'hFB3EE249;
        applyStimulusB(1, 0, 0, '0);
        b_q.push_back('{sig: 32'hFB3EE249, pass: 1'b1});
        applyStimulusB(0, 0, 1, '0);
        checkOutput("b_zero_sig", b_sig, 32'hFB3EE249);
        checkOutput("b_zero_done", b_done, 1);

        // Restart from DONE clears pass on the same edge; rerun against a wrong golden.
        b_golden = 32'h0;
        applyStimulusB(1, 0, 0, '0);
        checkOutput("b_restart_pass", b_pass, 0);
        checkOutput("b_restart_busy", b_busy, 1);
        checkOutput("b_restart_sig", b_sig, SEED);
        b_q.push_back('{sig: 32'hFB3EE249, pass: 1'b0});
        applyStimulusB(0, 0, 1, '0);

        // All-ones response.
        b_golden = 32'h04C11249;
        applyStimulusB(1, 0, 0, '0);
        b_q.push_back('{sig: 32'h04C11249, pass: 1'b1});
        applyStimulusB(0, 0, 1, {108{1'b1}});
        checkOutput("b_ones_sig", b_sig, 32'h04C11249);
        checkOutput("b_ones_pass", b_pass, 1);

        // start and abort together in DONE: abort wins.
        applyStimulusB(1, 1, 0, '0);
        checkOutput("b_startabort_flags", {b_busy, b_done, b_pass}, 0);
        checkOutput("b_startabort_sig", b_sig, 32'h04C11249);

        // Full-length run, valid on every third cycle.
        model = SEED;
        for (int i = 0; i < 31; i++) begin
            vecs[i] = rand108();
            model   = ref_step(model, vecs[i]);
        end
        a_golden = model;
        a_q.push_back('{sig: model, pass: 1'b1});
        applyStimulus(1, 0, 0, '0);
        model = SEED;
        for (int i = 0; i < 31; i++) begin
            model = ref_step(model, vecs[i]);
            applyStimulus(0, 0, 1, vecs[i]);
            checkOutput($sformatf("run_count_%0d", i), a_count, i + 1);
            checkOutput($sformatf("run_sig_%0d", i), a_sig, model);
            checkOutput($sformatf("run_done_%0d", i), a_done, (i == 30));
            tick();
            tick();
        end
        checkOutput("run_pass", a_pass, 1);
        applyStimulus(0, 0, 1, rand108());
        checkOutput("frozen_sig", a_sig, model);
        checkOutput("frozen_count", a_count, 31);
        checkOutput("frozen_done", a_done, 1);
        checkOutput("a_done_once", a_done_rises, 1);

        // Restart from DONE, then abort together with a response at vec_count=10.
        applyStimulus(1, 0, 0, '0);
        checkOutput("a_restart_pass", a_pass, 0);
        model = SEED;
        for (int i = 0; i < 10; i++) begin
            a_data = rand108();
            model  = ref_step(model, a_data);
            applyStimulus(0, 0, 1, a_data);
        end
        applyStimulus(0, 1, 1, rand108());
        checkOutput("abort_count", a_count, 10);
        checkOutput("abort_sig", a_sig, model);
        checkOutput("abort_flags", {a_busy, a_done, a_pass}, 0);
        tick();
        checkOutput("idle_hold_sig", a_sig, model);

        // Fresh start from IDLE, then start pulses inside RUN are ignored.
        applyStimulus(1, 0, 0, '0);
        checkOutput("restart_sig", a_sig, SEED);
        checkOutput("restart_count", a_count, 0);
        model = SEED;
        for (int i = 0; i < 2; i++) begin
            a_data = rand108();
            model  = ref_step(model, a_data);
            applyStimulus(0, 0, 1, a_data);
        end
        held = a_sig;
        applyStimulus(1, 0, 0, '0);
        checkOutput("run_start_sig", held, model);
        checkOutput("run_start_hold", a_sig, model);
        checkOutput("run_start_count", a_count, 2);
        checkOutput("run_start_busy", a_busy, 1);
        applyStimulus(0, 1, 0, '0);
        checkOutput("final_abort_busy", a_busy, 0);

        tick();
        tick();
        checkOutput("a_queue_empty", a_q.size(), 0);
        checkOutput("b_queue_empty", b_q.size(), 0);
        checkOutput("b_done_rises", b_done_rises, 3);
        checkOutput("a_done_rises", a_done_rises, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
